reg_file_ser_master: RTL and testbench
======================================

// Module: reg_file_ser_master
// PURPOSE
//  Host-side sequencer for the serial register file. Accepts one parallel read/write
//  request at a time, serialises it onto the RF strobe/DIN lines (strobe, address, data),
//  captures RF_DOUT for reads, returns a one-cycle response. Sole bus owner of the register file.
// PARAMETERS
//  ADDR_WIDTH  8  register address width, bits shifted MSB first
//  DATA_WIDTH  8  register data width, bits shifted/sampled MSB first
//  RD_LAT      1  turnaround cycles between last address bit and first RF_DOUT sample (0..7)
// PORTS
//  CLK          in   1           clock, all logic on posedge
//  RSTN         in   1           asynchronous active-low reset
//  REQ_VALID    in   1           request present
//  REQ_READY    out  1           controller idle, request accepted when VALID&&READY
//  REQ_WR       in   1           1 = write, 0 = read
//  REQ_ADDR     in   ADDR_WIDTH  target register address
//  REQ_WDATA    in   DATA_WIDTH  write data
//  RSP_VALID    out  1           one-cycle response pulse
//  RSP_RDATA    out  DATA_WIDTH  read (or readback) data, held until next RSP_VALID
//  RSP_ERR      out  1           readback mismatch, valid with RSP_VALID
//  BUSY         out  1           transaction in progress (state != IDLE)
//  RF_WR_EN     out  1           write strobe to register file
//  RF_RD_EN     out  1           read strobe to register file
//  RF_DIN       out  1           serial address/data to register file
//  RF_DOUT      in   1           serial read data from register file
// BEHAVIOUR
//  Reset: state IDLE, REQ_READY=1, BUSY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0,
//   RF_WR_EN=0, RF_RD_EN=0, RF_DIN=0. All outputs registered except REQ_READY=(state==IDLE).
//  FSM: IDLE -> STRB -> ADDR -> {WDATA | TURN -> RDATA} -> RESP -> IDLE.
//  Accept at edge T0 (latch REQ_WR/ADDR/WDATA); request fields ignored at all other times.
//  STRB, 1 cycle (T1): RF_WR_EN=1 for write, RF_RD_EN=1 for read; RF_DIN=0. Strobes never both 1.
//  ADDR, ADDR_WIDTH cycles (T2..T9): RF_DIN = REQ_ADDR MSB first; 3..4-bit bit counter.
//  WDATA, DATA_WIDTH cycles (T10..T17): RF_DIN = REQ_WDATA MSB first; then RESP.
//  TURN, RD_LAT cycles (skipped when RD_LAT=0): RF_DIN=0.
//  RDATA, DATA_WIDTH cycles: RF_DOUT sampled each edge into shift reg, MSB first.
//  RESP, 1 cycle: RSP_VALID=1; RSP_RDATA updated for reads; back to IDLE.
//  Latency accept->RSP_VALID: write 18 cycles; read 10+RD_LAT+DATA_WIDTH (19 at defaults).
//  Back-to-back: new request accepted at the first IDLE cycle after RESP (1 dead cycle).
//  RF_DIN=0 in every state other than ADDR/WDATA.
//  Reset mid-transaction: immediate return to reset values; no RSP_VALID for the aborted request.
//  REQ_VALID held during BUSY: no effect, request stays pending until READY.
// CONFIGURATION
//  REG_FILE_SER_MASTER_WRVERIFY_EN defined: after WDATA, a write re-enters STRB as a read of
//   the same address (TURN/RDATA as above); RESP reports RSP_RDATA=readback,
//   RSP_ERR=(readback!=REQ_WDATA). Write latency 36 cycles at defaults.
//  Not defined: writes go WDATA->RESP; RSP_ERR tied 0; RSP_RDATA unchanged on writes.
// TESTING
//  Write addr 0x55 data 0xA5 -> RF_WR_EN high T1 only; RF_DIN T2..T17 = 01010101 10100101; RSP_VALID at T18.
//  Read addr 0x34, model drives RF_DOUT=0x3C bits from T11 -> RF_RD_EN T1, RSP_VALID T19, RSP_RDATA=0x3C.
//  RD_LAT=0 and RD_LAT=3 reads of 0x78 -> sampling window shifts by RD_LAT; RSP_VALID at T18 / T21.
//  Two queued requests (write 0xA1<-0x0F, read 0xA1) -> second accepted exactly 1 cycle after first RSP.
//  RSTN low at T6 of a write -> all outputs reset asynchronously, no RSP_VALID, next request runs normally.
//  WRVERIFY_EN, model returns 0x00 after write 0x06<-0xFF -> RSP_ERR=1, RSP_RDATA=0x00 at T36; match -> RSP_ERR=0.

Source files
------------

// File: rtl/reg_file_ser_master_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_ser_master_if
// Description : Bus bundle for the serial register-file host sequencer.
//               Carries the parallel request/response handshake and the
//               serial strobe/DIN/DOUT lines to the register file.
//               master modport : the sequencer (reg_file_ser_master)
//               slave modport  : the requester / register-file side
// Signals     : REQ_VALID/REQ_READY/REQ_WR/REQ_ADDR/REQ_WDATA  request
//               RSP_VALID/RSP_RDATA/RSP_ERR                   response
//               BUSY                                          status
//               RF_WR_EN/RF_RD_EN/RF_DIN/RF_DOUT              serial RF bus
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_ser_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WR;
  logic [ADDR_WIDTH-1:0] REQ_ADDR;
  logic [DATA_WIDTH-1:0] REQ_WDATA;
  logic                  RSP_VALID;
  logic [DATA_WIDTH-1:0] RSP_RDATA;
  logic                  RSP_ERR;
  logic                  BUSY;
  logic                  RF_WR_EN;
  logic                  RF_RD_EN;
  logic                  RF_DIN;
  logic                  RF_DOUT;

  modport master (
    input  REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, RF_DOUT,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
           RF_WR_EN, RF_RD_EN, RF_DIN
  );

  modport slave (
    output REQ_VALID, REQ_WR, REQ_ADDR, REQ_WDATA, RF_DOUT,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, BUSY,
           RF_WR_EN, RF_RD_EN, RF_DIN
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_ser_master.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_ser_master
// Description : Host-side sequencer for the serial register file. Accepts one
//               parallel read/write request at a time, shifts strobe, address
//               and data out on RF_DIN (MSB first), captures RF_DOUT for
//               reads and returns a one-cycle response.
// Ports       : CLK   - clock, posedge
//               RSTN  - asynchronous active-low reset
//               bus   - reg_file_ser_master_if.master (request, response,
//                       BUSY and serial register-file lines)
// Parameters  : ADDR_WIDTH, DATA_WIDTH, RD_LAT (turnaround cycles, 0..7)
// Option      : REG_FILE_SER_MASTER_WRVERIFY_EN - writes are followed by a
//               readback of the same address; RSP_ERR flags a mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_ser_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input wire logic              CLK,
  input wire logic              RSTN,
  reg_file_ser_master_if.master bus
);

  localparam int c_span  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  // Counter must also cover RD_LAT up to 7, hence the 3-bit floor.
  localparam int c_cnt_w = ($clog2(c_span) > 3) ? $clog2(c_span) : 3;
  localparam logic [c_cnt_w-1:0] c_addr_load = c_cnt_w'(ADDR_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_data_load = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_turn_load = (RD_LAT > 0) ? c_cnt_w'(RD_LAT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STRB  = 3'd1,
    S_ADDR  = 3'd2,
    S_WDATA = 3'd3,
    S_TURN  = 3'd4,
    S_RDATA = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_cnt_w-1:0]    w_cnt_load;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  w_wr_pass;
  logic                  r_samp;
  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_next;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_busy;
  logic                  r_wr_en;
  logic                  r_rd_en;
  logic                  r_din;

`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
  // Set once the data phase of a write is done; the transaction then runs
  // a second strobe/address pass as a read of the same register.
  logic r_verify;
  logic r_rsp_err;
  assign w_wr_pass = r_wr && !r_verify;
`else
  assign w_wr_pass = r_wr;
`endif

  // The last data bit is sampled on the same edge that publishes the
  // response, so the response uses the shift register plus the live input.
  assign w_shift_next = {r_shift, bus.RF_DOUT};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.REQ_VALID) begin
          w_next   = S_STRB;
          w_accept = 1'b1;
        end
      end
      S_STRB:  w_next = S_ADDR;
      S_ADDR: begin
        if (r_cnt == '0) begin
          if (w_wr_pass)        w_next = S_WDATA;
          else if (RD_LAT > 0)  w_next = S_TURN;
          else                  w_next = S_RDATA;
        end
      end
      S_WDATA: begin
        if (r_cnt == '0) begin
`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
          w_next = S_STRB;
`else
          w_next = S_RESP;
`endif
        end
      end
      S_TURN:  if (r_cnt == '0) w_next = S_RDATA;
      S_RDATA: if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_load = '0;
    case (w_next)
      S_ADDR:  w_cnt_load = c_addr_load;
      S_WDATA: w_cnt_load = c_data_load;
      S_TURN:  w_cnt_load = c_turn_load;
      S_RDATA: w_cnt_load = c_data_load;
      default: w_cnt_load = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs. Serial outputs are decoded from the
  // current state and therefore appear one cycle after the state is entered.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_samp      <= 1'b0;
      r_shift     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_din       <= 1'b0;
    end else begin
      if (w_next != r_state) begin
        r_cnt <= w_cnt_load;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_accept) begin
        r_wr    <= bus.REQ_WR;
        r_addr  <= bus.REQ_ADDR;
        r_wdata <= bus.REQ_WDATA;
      end

      r_busy  <= (w_next != S_IDLE);
      r_wr_en <= (r_state == S_STRB) &&  w_wr_pass;
      r_rd_en <= (r_state == S_STRB) && !w_wr_pass;

      case (r_state)
        S_ADDR:  r_din <= r_addr[r_cnt];
        S_WDATA: r_din <= r_wdata[r_cnt];
        default: r_din <= 1'b0;
      endcase

      // Sampling trails the RDATA state by one cycle to line up with the
      // delayed strobe/address seen by the register file.
      r_samp <= (r_state == S_RDATA);
      if (r_samp) begin
        r_shift <= w_shift_next[DATA_WIDTH-2:0];
      end

      r_rsp_valid <= (r_state == S_RESP);
      if ((r_state == S_RESP) && !r_wr) begin
        r_rsp_rdata <= w_shift_next;
      end
`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
      if ((r_state == S_RESP) && r_wr) begin
        r_rsp_rdata <= w_shift_next;
      end
`endif
    end
  end

`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_verify  <= 1'b0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_verify <= 1'b0;
      end else if ((r_state == S_WDATA) && (w_next == S_STRB)) begin
        r_verify <= 1'b1;
      end
      if (r_state == S_RESP) begin
        r_rsp_err <= r_wr && (w_shift_next != r_wdata);
      end
    end
  end
  assign bus.RSP_ERR = r_rsp_err;
`else
  assign bus.RSP_ERR = 1'b0;
`endif

  assign bus.REQ_READY = (r_state == S_IDLE);
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_RDATA = r_rsp_rdata;
  assign bus.BUSY      = r_busy;
  assign bus.RF_WR_EN  = r_wr_en;
  assign bus.RF_RD_EN  = r_rd_en;
  assign bus.RF_DIN    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_ser_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_ser_master
// Description : Directed self-checking bench for reg_file_ser_master. Three
//               instances (RD_LAT = 1, 0, 3) share clock and reset; one is
//               selected at a time for stimulus and observation. Tn is the
//               cycle that begins at the n-th rising edge after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_ser_master;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       t_valid = 1'b0;
  logic       t_wr = 1'b0;
  logic [7:0] t_addr = 8'h00;
  logic [7:0] t_wdata = 8'h00;
  logic       t_dout = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 CLK = ~CLK;

  reg_file_ser_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus0 ();
  reg_file_ser_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus1 ();
  reg_file_ser_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus2 ();

  reg_file_ser_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(1)) u_dut0 (.CLK(CLK), .RSTN(RSTN), .bus(bus0));
  reg_file_ser_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(0)) u_dut1 (.CLK(CLK), .RSTN(RSTN), .bus(bus1));
  reg_file_ser_master #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LAT(3)) u_dut2 (.CLK(CLK), .RSTN(RSTN), .bus(bus2));

  assign bus0.REQ_VALID = t_valid && (sel == 2'd0);
  assign bus1.REQ_VALID = t_valid && (sel == 2'd1);
  assign bus2.REQ_VALID = t_valid && (sel == 2'd2);
  assign bus0.RF_DOUT   = t_dout && (sel == 2'd0);
  assign bus1.RF_DOUT   = t_dout && (sel == 2'd1);
  assign bus2.RF_DOUT   = t_dout && (sel == 2'd2);
  assign bus0.REQ_WR = t_wr;   assign bus0.REQ_ADDR = t_addr;   assign bus0.REQ_WDATA = t_wdata;
  assign bus1.REQ_WR = t_wr;   assign bus1.REQ_ADDR = t_addr;   assign bus1.REQ_WDATA = t_wdata;
  assign bus2.REQ_WR = t_wr;   assign bus2.REQ_ADDR = t_addr;   assign bus2.REQ_WDATA = t_wdata;

  logic       o_ready, o_busy, o_rsp_valid, o_err, o_wen, o_ren, o_din;
  logic [7:0] o_rdata;
  assign o_ready     = (sel == 2'd1) ? bus1.REQ_READY : (sel == 2'd2) ? bus2.REQ_READY : bus0.REQ_READY;
  assign o_busy      = (sel == 2'd1) ? bus1.BUSY      : (sel == 2'd2) ? bus2.BUSY      : bus0.BUSY;
  assign o_rsp_valid = (sel == 2'd1) ? bus1.RSP_VALID : (sel == 2'd2) ? bus2.RSP_VALID : bus0.RSP_VALID;
  assign o_rdata     = (sel == 2'd1) ? bus1.RSP_RDATA : (sel == 2'd2) ? bus2.RSP_RDATA : bus0.RSP_RDATA;
  assign o_err       = (sel == 2'd1) ? bus1.RSP_ERR   : (sel == 2'd2) ? bus2.RSP_ERR   : bus0.RSP_ERR;
  assign o_wen       = (sel == 2'd1) ? bus1.RF_WR_EN  : (sel == 2'd2) ? bus2.RF_WR_EN  : bus0.RF_WR_EN;
  assign o_ren       = (sel == 2'd1) ? bus1.RF_RD_EN  : (sel == 2'd2) ? bus2.RF_RD_EN  : bus0.RF_RD_EN;
  assign o_din       = (sel == 2'd1) ? bus1.RF_DIN    : (sel == 2'd2) ? bus2.RF_DIN    : bus0.RF_DIN;

  // Issues one request and records per-cycle strobes/DIN/BUSY until the
  // response (or a 45-cycle budget, leaving rsp = -1). The register-file
  // model drives rb MSB first on RF_DOUT during cycles rstart..rstart+7.
  task automatic run_txn(input logic [1:0] s, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] rb, input int rstart,
                         output int rsp, output logic [63:0] din, output logic [63:0] wen,
                         output logic [63:0] ren, output logic [63:0] bsy,
                         output logic [7:0] rdata, output logic err);
    int guard;
    guard = 0;
    sel = s;
    rsp = -1; din = '0; wen = '0; ren = '0; bsy = '0; rdata = 8'h00; err = 1'b0;
    @(negedge CLK);
    while (!o_ready && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    t_valid = 1'b1; t_wr = wr; t_addr = a; t_wdata = d;
    @(posedge CLK);
    #1;
    t_valid = 1'b0; t_wr = ~wr; t_addr = ~a; t_wdata = ~d;
    for (int n = 1; n <= 45; n++) begin
      @(posedge CLK);
      #1;
      t_dout = (n >= rstart && n < rstart + 8) ? rb[7 - (n - rstart)] : 1'b0;
      din[n] = o_din; wen[n] = o_wen; ren[n] = o_ren; bsy[n] = o_busy;
      if (o_rsp_valid) begin
        rsp = n; rdata = o_rdata; err = o_err;
        break;
      end
    end
    t_dout = 1'b0;
  endtask

  task automatic test_reset();
    sel = 2'd0;
    n_checks++; if (o_ready !== 1'b1)     begin n_errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
    n_checks++; if (o_busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_checks++; if (o_rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid got %b want 0", o_rsp_valid); end
    n_checks++; if (o_rdata !== 8'h00)    begin n_errors++; $display("FAIL reset_rdata got %h want 00", o_rdata); end
    n_checks++; if (o_err !== 1'b0)       begin n_errors++; $display("FAIL reset_err got %b want 0", o_err); end
    n_checks++; if ({o_wen, o_ren, o_din} !== 3'b000) begin n_errors++; $display("FAIL reset_rf_lines got %b want 000", {o_wen, o_ren, o_din}); end
  endtask

  task automatic test_write();
    int rsp; logic [63:0] din, wen, ren, bsy; logic [7:0] rdata; logic err; logic [15:0] got;
`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
    run_txn(2'd0, 1'b1, 8'h55, 8'hA5, 8'hA5, 28, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (rsp !== 36)        begin n_errors++; $display("FAIL write_latency got %0d want 36", rsp); end
    n_checks++; if (rdata !== 8'hA5)   begin n_errors++; $display("FAIL write_readback got %h want a5", rdata); end
    n_checks++; if (ren !== (64'h1 << 18)) begin n_errors++; $display("FAIL write_verify_rd_en got %h want %h", ren, 64'h1 << 18); end
`else
    run_txn(2'd0, 1'b1, 8'h55, 8'hA5, 8'h00, 100, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (rsp !== 18)        begin n_errors++; $display("FAIL write_latency got %0d want 18", rsp); end
    n_checks++; if (rdata !== 8'h00)   begin n_errors++; $display("FAIL write_rdata_held got %h want 00", rdata); end
    n_checks++; if (ren !== 64'h0)     begin n_errors++; $display("FAIL write_rd_en got %h want 0", ren); end
    n_checks++; if (din[18] !== 1'b0)  begin n_errors++; $display("FAIL write_din_resp got %b want 0", din[18]); end
`endif
    got = '0;
    for (int n = 2; n <= 17; n++) got = {got[14:0], din[n]};
    n_checks++; if (got !== 16'h55A5)  begin n_errors++; $display("FAIL write_din_stream got %h want 55a5", got); end
    n_checks++; if (din[1] !== 1'b0)   begin n_errors++; $display("FAIL write_din_strobe got %b want 0", din[1]); end
    n_checks++; if (wen !== 64'h2)     begin n_errors++; $display("FAIL write_wr_en got %h want 2", wen); end
    n_checks++; if (err !== 1'b0)      begin n_errors++; $display("FAIL write_err got %b want 0", err); end
    n_checks++; if (bsy[17:1] !== 17'h1FFFF) begin n_errors++; $display("FAIL write_busy got %h want 1ffff", bsy[17:1]); end
  endtask

  task automatic test_read();
    int rsp; logic [63:0] din, wen, ren, bsy; logic [7:0] rdata; logic err; logic [7:0] got;
    run_txn(2'd0, 1'b0, 8'h34, 8'h00, 8'h3C, 11, rsp, din, wen, ren, bsy, rdata, err);
    got = '0;
    for (int n = 2; n <= 9; n++) got = {got[6:0], din[n]};
    n_checks++; if (rsp !== 19)       begin n_errors++; $display("FAIL read_latency got %0d want 19", rsp); end
    n_checks++; if (rdata !== 8'h3C)  begin n_errors++; $display("FAIL read_rdata got %h want 3c", rdata); end
    n_checks++; if (ren !== 64'h2)    begin n_errors++; $display("FAIL read_rd_en got %h want 2", ren); end
    n_checks++; if (wen !== 64'h0)    begin n_errors++; $display("FAIL read_wr_en got %h want 0", wen); end
    n_checks++; if (got !== 8'h34)    begin n_errors++; $display("FAIL read_addr_stream got %h want 34", got); end
    n_checks++; if (din[19:10] !== 10'h0) begin n_errors++; $display("FAIL read_din_idle got %h want 0", din[19:10]); end
    n_checks++; if (bsy[rsp] !== 1'b0) begin n_errors++; $display("FAIL read_busy_after got %b want 0", bsy[rsp]); end
  endtask

  task automatic test_rd_lat();
    int rsp; logic [63:0] din, wen, ren, bsy; logic [7:0] rdata; logic err;
    run_txn(2'd1, 1'b0, 8'h78, 8'h00, 8'hC3, 10, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (rsp !== 18)       begin n_errors++; $display("FAIL lat0_latency got %0d want 18", rsp); end
    n_checks++; if (rdata !== 8'hC3)  begin n_errors++; $display("FAIL lat0_rdata got %h want c3", rdata); end
    run_txn(2'd2, 1'b0, 8'h78, 8'h00, 8'h5A, 13, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (rsp !== 21)       begin n_errors++; $display("FAIL lat3_latency got %0d want 21", rsp); end
    n_checks++; if (rdata !== 8'h5A)  begin n_errors++; $display("FAIL lat3_rdata got %h want 5a", rdata); end
    n_checks++; if (din[12:10] !== 3'b000) begin n_errors++; $display("FAIL lat3_turn_din got %b want 000", din[12:10]); end
    sel = 2'd0;
  endtask

  task automatic test_back_to_back();
    int rsp1, rsp2, acc2, s1;
    logic [7:0] rd2, data_b;
    logic [15:0] got;
    rsp1 = -1; rsp2 = -1; acc2 = -1; rd2 = 8'h00; got = '0; data_b = 8'h0F;
`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
    s1 = 28;
`else
    s1 = 1000;
`endif
    sel = 2'd0;
    @(negedge CLK);
    t_valid = 1'b1; t_wr = 1'b1; t_addr = 8'hA1; t_wdata = 8'h0F;
    @(posedge CLK);
    #1;
    t_wr = 1'b0; t_addr = 8'hA1; t_wdata = 8'h00;
    for (int c = 1; c <= 90; c++) begin
      @(posedge CLK);
      #1;
      if (c >= 2 && c <= 17) got = {got[14:0], o_din};
      if (o_rsp_valid) begin
        if (rsp1 < 0) rsp1 = c;
        else if (rsp2 < 0) begin rsp2 = c; rd2 = o_rdata; end
      end
      if (acc2 < 0 && rsp1 > 0 && c > rsp1 && o_busy) begin
        acc2 = c;
        t_valid = 1'b0;
      end
      if (c >= s1 && c < s1 + 8) t_dout = data_b[7 - (c - s1)];
      else if (acc2 >= 0 && c >= acc2 + 11 && c < acc2 + 19) t_dout = data_b[7 - (c - acc2 - 11)];
      else t_dout = 1'b0;
      if (rsp2 >= 0) break;
    end
    t_valid = 1'b0; t_dout = 1'b0;
`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
    n_checks++; if (rsp1 !== 36)   begin n_errors++; $display("FAIL b2b_first_latency got %0d want 36", rsp1); end
`else
    n_checks++; if (rsp1 !== 18)   begin n_errors++; $display("FAIL b2b_first_latency got %0d want 18", rsp1); end
`endif
    n_checks++; if (got !== 16'hA10F) begin n_errors++; $display("FAIL b2b_write_stream got %h want a10f", got); end
    n_checks++; if (acc2 - rsp1 !== 1) begin n_errors++; $display("FAIL b2b_accept_gap got %0d want 1", acc2 - rsp1); end
    n_checks++; if (rsp2 - acc2 !== 19) begin n_errors++; $display("FAIL b2b_second_latency got %0d want 19", rsp2 - acc2); end
    n_checks++; if (rd2 !== 8'h0F) begin n_errors++; $display("FAIL b2b_rdata got %h want 0f", rd2); end
  endtask

  task automatic test_reset_mid();
    int rsp, nrsp; logic [63:0] din, wen, ren, bsy; logic [7:0] rdata; logic err;
    sel = 2'd0;
    nrsp = 0;
    @(negedge CLK);
    t_valid = 1'b1; t_wr = 1'b1; t_addr = 8'hFF; t_wdata = 8'h81;
    @(posedge CLK);
    #1;
    t_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge CLK);
      #1;
    end
    n_checks++; if (o_din !== 1'b1) begin n_errors++; $display("FAIL mid_din_active got %b want 1", o_din); end
    RSTN = 1'b0;
    #1;
    n_checks++; if (o_busy !== 1'b0)  begin n_errors++; $display("FAIL mid_busy got %b want 0", o_busy); end
    n_checks++; if (o_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready got %b want 1", o_ready); end
    n_checks++; if (o_din !== 1'b0)   begin n_errors++; $display("FAIL mid_din got %b want 0", o_din); end
    n_checks++; if (o_rdata !== 8'h00) begin n_errors++; $display("FAIL mid_rdata got %h want 00", o_rdata); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge CLK);
      #1;
      if (o_rsp_valid) nrsp++;
    end
    n_checks++; if (nrsp !== 0) begin n_errors++; $display("FAIL mid_no_response got %0d want 0", nrsp); end
    run_txn(2'd0, 1'b0, 8'h34, 8'h00, 8'h96, 11, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (rsp !== 19)      begin n_errors++; $display("FAIL mid_next_latency got %0d want 19", rsp); end
    n_checks++; if (rdata !== 8'h96) begin n_errors++; $display("FAIL mid_next_rdata got %h want 96", rdata); end
  endtask

`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
  task automatic test_wrverify();
    int rsp; logic [63:0] din, wen, ren, bsy; logic [7:0] rdata; logic err;
    run_txn(2'd0, 1'b1, 8'h06, 8'hFF, 8'h00, 28, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (rsp !== 36)      begin n_errors++; $display("FAIL verify_bad_latency got %0d want 36", rsp); end
    n_checks++; if (err !== 1'b1)    begin n_errors++; $display("FAIL verify_bad_err got %b want 1", err); end
    n_checks++; if (rdata !== 8'h00) begin n_errors++; $display("FAIL verify_bad_rdata got %h want 00", rdata); end
    run_txn(2'd0, 1'b1, 8'h06, 8'hFF, 8'hFF, 28, rsp, din, wen, ren, bsy, rdata, err);
    n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL verify_ok_err got %b want 0", err); end
    n_checks++; if (rdata !== 8'hFF) begin n_errors++; $display("FAIL verify_ok_rdata got %h want ff", rdata); end
  endtask
`endif

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    test_reset();
    test_write();
    test_read();
    test_rd_lat();
    test_back_to_back();
    test_reset_mid();
`ifdef REG_FILE_SER_MASTER_WRVERIFY_EN
    test_wrverify();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
